vga_fb_arbiter: RTL and testbench

Shares one single-port, synchronous-read frame-buffer RAM between VGA scan-out and a graphics writer. The frame buffer holds 160x120 pixels at 8 bits each and is shown on the 640x480 display at 4x scale in both directions. The block sits between the `vga` timing module (it consumes `hc_out`/`vc_out`) and the frame-buffer RAM. It prefetches each pixel so that `pixel` is valid exactly when `hc`/`vc` reach it. Display reads have absolute priority; writes use every other RAM cycle through a valid/ready handshake.

---
 rtl/vga_fb_arbiter_if.sv | 19 +
 rtl/vga_fb_arbiter.sv | 96 +++++++++
 tb/tb_vga_fb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Writer-side handshake into the frame-buffer arbiter.
// Ports: wr_valid/wr_ready, wr_x (column), wr_y (row), wr_data (pixel).
interface vga_fb_arbiter_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_data;

  modport master (
    output wr_valid, wr_x, wr_y, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one sync-read frame-buffer RAM between VGA scan-out and a writer.
// Ports: vgaclk/rst, hc/vc in, pixel/frame_start out, wr (handshake),
//        ram_addr/ram_we/ram_wdata/ram_rdata (RAM), oob_count (drops).
module vga_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15
) (
  input  logic              vgaclk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  output logic [7:0]        pixel,
  output logic              frame_start,
  vga_fb_arbiter_if.slave   wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [15:0]       oob_count
);

  // Row stride of 160 = 128 + 32, so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] fb_addr(
    input logic [6:0] y,
    input logic [7:0] x
  );
    return ADDR_W'({y, 7'b0}) + ADDR_W'({y, 5'b0}) + ADDR_W'(x);
  endfunction

  logic        wrap;
  logic [9:0]  hn;
  logic [9:0]  vn;
  logic        active;
  logic        read_slot;
  logic        in_range;
  logic        xfer;
  logic        wr_hit;
  logic        rd_pend;
  logic        act_pend;

  // Lookahead two clocks ahead so the sync-read RAM lands on time.
  always_comb begin
    wrap      = (hc >= 10'd798);
    hn        = wrap ? (hc - 10'd798) : (hc + 10'd2);
    vn        = vc;
    if (wrap)
      vn = (vc == 10'd524) ? 10'd0 : (vc + 10'd1);
    active    = (hn < 10'd640) && (vn < 10'd480);
    read_slot = active && (hn[1:0] == 2'b00);
  end

  always_comb begin
    in_range    = (32'(wr.wr_x) < FB_W) && (32'(wr.wr_y) < FB_H);
    wr.wr_ready = ~rst & ~read_slot;
    xfer        = wr.wr_valid & wr.wr_ready;
    wr_hit      = xfer & in_range;
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    unique case (1'b1)
      read_slot: ram_addr = fb_addr(vn[8:2], hn[9:2]);
      wr_hit: begin
        ram_addr  = fb_addr(wr.wr_y, wr.wr_x);
        ram_we    = 1'b1;
        ram_wdata = wr.wr_data;
      end
      default: ;
    endcase
  end

  // Pixel holds between reads; blanks to 0 outside the active area.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      rd_pend     <= 1'b0;
      act_pend    <= 1'b0;
      pixel       <= 8'h00;
      frame_start <= 1'b0;
      oob_count   <= 16'h0000;
    end else begin
      rd_pend     <= read_slot;
      act_pend    <= active;
      frame_start <= (hc == 10'd0) && (vc == 10'd480);
      if (rd_pend)
        pixel <= ram_rdata;
      else if (!act_pend)
        pixel <= 8'h00;
      if (xfer && !in_range && oob_count != 16'hFFFF)
        oob_count <= oob_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter.
// Drives hc/vc directly and models the sync-read RAM.
module tb_vga_fb_arbiter;

  logic        vgaclk = 1'b0;
  logic        rst;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [7:0]  pixel;
  logic        frame_start;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [15:0] oob_count;
  logic [7:0]  mem [0:19199];

  int tests = 0;
  int fails = 0;
  int acc   = 0;

  vga_fb_arbiter_if wr_if ();

  vga_fb_arbiter dut (
    .vgaclk      (vgaclk),
    .rst         (rst),
    .hc          (hc),
    .vc          (vc),
    .pixel       (pixel),
    .frame_start (frame_start),
    .wr          (wr_if.slave),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .oob_count   (oob_count)
  );

  always #20 vgaclk = ~vgaclk;

  always @(posedge vgaclk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge vgaclk);
    #1;
    if (hc == 10'd799) begin
      hc = 10'd0;
      vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
    end else begin
      hc = hc + 10'd1;
    end
    #1;
  endtask

  task automatic set_pos(input int h, input int v);
    hc = 10'(h);
    vc = 10'(v);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 8'h00;
    mem[0]   = 8'hE0;
    mem[1]   = 8'h1C;
    mem[160] = 8'h55;
    rst = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_x = 8'd5;
    wr_if.wr_y = 7'd5;
    wr_if.wr_data = 8'h11;
    hc = 10'd100;
    vc = 10'd490;

    // reset with a pending write
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_pixel", 32'(pixel), 32'h0);
      chk("rst_fs", 32'(frame_start), 32'h0);
      chk("rst_oob", 32'(oob_count), 32'h0);
      chk("rst_ready", 32'(wr_if.wr_ready), 32'h0);
      chk("rst_we", 32'(ram_we), 32'h0);
    end
    rst = 1'b0;
    wr_if.wr_valid = 1'b0;

    // alignment: first pixel of frame read at 798/524
    set_pos(797, 524);
    cyc();
    chk("align_addr", 32'(ram_addr), 32'd0);
    chk("align_ready", 32'(wr_if.wr_ready), 32'h0);
    cyc();
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("align_pix", 32'(pixel), (i < 4) ? 32'hE0 : 32'h1C);
      cyc();
    end

    // arbitration at the start of line 0
    set_pos(1, 0);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_x = 8'd3;
    wr_if.wr_y = 7'd0;
    wr_if.wr_data = 8'hAA;
    #1;
    chk("arb_h1_ready", 32'(wr_if.wr_ready), 32'h1);
    chk("arb_h1_addr", 32'(ram_addr), 32'd3);
    cyc();
    chk("arb_h2_ready", 32'(wr_if.wr_ready), 32'h0);
    chk("arb_h2_we", 32'(ram_we), 32'h0);
    chk("arb_h2_addr", 32'(ram_addr), 32'd1);
    cyc();
    chk("arb_h3_we", 32'(ram_we), 32'h1);
    chk("arb_h3_addr", 32'(ram_addr), 32'd3);
    chk("arb_h3_data", 32'(ram_wdata), 32'hAA);
    cyc();
    wr_if.wr_valid = 1'b0;

    // written pixel shows on rows 0..3, columns 12..15
    for (int v = 0; v < 4; v++) begin
      set_pos(9, v);
      cyc();
      cyc();
      cyc();
      for (int k = 0; k < 4; k++) begin
        chk("arb_pix", 32'(pixel), 32'hAA);
        cyc();
      end
    end

    // scaling: row 1 starts at 798 of line 4
    set_pos(797, 4);
    cyc();
    chk("scale_addr", 32'(ram_addr), 32'd160);
    cyc();
    cyc();
    chk("scale_pix", 32'(pixel), 32'h55);
    for (int v = 4; v < 8; v++) begin
      set_pos(2, v);
      chk("scale_h2", 32'(ram_addr), 32'd161);
      set_pos(6, v);
      chk("scale_h6", 32'(ram_addr), 32'd162);
    end

    // frame_start
    set_pos(799, 479);
    cyc();
    chk("fs_before", 32'(frame_start), 32'h0);
    cyc();
    chk("fs_pulse", 32'(frame_start), 32'h1);
    cyc();
    chk("fs_after", 32'(frame_start), 32'h0);

    // blanking throughput on line 490
    set_pos(0, 490);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_y = 7'd100;
    for (int i = 0; i < 800; i++) begin
      wr_if.wr_x = 8'(i % 160);
      wr_if.wr_data = 8'(i);
      #1;
      if (wr_if.wr_ready && ram_we) acc++;
      cyc();
    end
    chk("blank_accepts", 32'(acc), 32'd800);
    chk("blank_mem", 32'(mem[16005]), 32'h85);

    // out of range writes
    set_pos(100, 490);
    wr_if.wr_x = 8'd160;
    wr_if.wr_y = 7'd0;
    #1;
    chk("oob_ready", 32'(wr_if.wr_ready), 32'h1);
    chk("oob_we", 32'(ram_we), 32'h0);
    chk("oob_addr", 32'(ram_addr), 32'd0);
    cyc();
    chk("oob_x", 32'(oob_count), 32'd1);
    wr_if.wr_x = 8'd0;
    wr_if.wr_y = 7'd120;
    cyc();
    chk("oob_y", 32'(oob_count), 32'd2);
    wr_if.wr_x = 8'd159;
    wr_if.wr_y = 7'd119;
    #1;
    chk("max_we", 32'(ram_we), 32'h1);
    chk("max_addr", 32'(ram_addr), 32'd19199);
    cyc();
    chk("max_no_oob", 32'(oob_count), 32'd2);
    wr_if.wr_x = 8'd160;
    repeat (65533) @(posedge vgaclk);
    #1;
    chk("oob_full", 32'(oob_count), 32'hFFFF);
    repeat (4) @(posedge vgaclk);
    #1;
    chk("oob_sat", 32'(oob_count), 32'hFFFF);
    wr_if.wr_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
